// File: rtl/alu_pkg.sv
// Shared opcodes, slice width and sequencer state encoding for the nibble alu family.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// 4-bit alu slice: add with carry, bitwise logic ops; unused opcodes give zero.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module alu
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic [2:0]          op,
    output logic [NIBBLE_W-1:0] y,
    output logic                cout
);

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
            OP_AND:  y = a & b;
            OP_NOR:  y = ~(a | b);
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs WIDTH-bit ops on one 4-bit alu, one nibble per cycle, carry chained LSB-first.
// Latency: done pulses NIBBLES+1 cycles after the accepting edge.
// Backpressure: ready only in IDLE; start while busy is dropped, not queued.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2:0]         op_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   res_acc;
    logic [NIBBLE_W-1:0] alu_y;
    logic               alu_co;

    alu u_alu (
        .a    (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .b    (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .cin  (carry),
        .op   (op_reg),
        .y    (alu_y),
        .cout (alu_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN) || (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            res_acc <= '0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        idx    <= '0;
                        // carry-in only seeds addition; logic ops start from a clean carry
                        carry  <= (op == OP_ADD) ? cin : 1'b0;
                    end
                end
                RUN: begin
                    res_acc[NIBBLE_W*idx +: NIBBLE_W] <= alu_y;
                    carry <= alu_co;
                    idx   <= idx + 1'b1;
                end
                DONE: begin
                    result <= res_acc;
                    cout   <= carry;
                    zero   <= (res_acc == '0);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a full-width arithmetic reference model.
module tb_alu_nibble_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_nibble_seq #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Full-width reference: {cout, result}
    function automatic logic [W:0] model_calc(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic ci);
        case (o)
            3'b000:  return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            3'b001:  return {1'b0, x & y};
            3'b010:  return {1'b0, ~(x | y)};
            3'b011:  return {1'b0, x | y};
            3'b100:  return {1'b0, ~x};
            3'b101:  return {1'b0, x ^ y};
            default: return '0;
        endcase
    endfunction

    // Transaction-level model: a command occupies the unit for 5 edges, then a done pulse.
    bit           m_pend;
    int           m_cnt;
    bit           m_done;
    logic [W-1:0] m_res;
    bit           m_cout;
    bit           m_zero;
    logic [W:0]   p_calc;

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_zero <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    m_pend <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= p_calc[W-1:0];
                    m_cout <= p_calc[W];
                    m_zero <= (p_calc[W-1:0] == '0);
                end
                m_cnt <= m_cnt - 1;
            end else if (start) begin
                m_pend <= 1'b1;
                m_cnt  <= 5;
                p_calc <= model_calc(op, a, b, cin);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready",  32'(ready),  32'(!m_pend));
            chk("m_busy",   32'(busy),   32'(m_pend));
            chk("m_done",   32'(done),   32'(m_done));
            chk("m_result", 32'(result), 32'(m_res));
            chk("m_cout",   32'(cout),   32'(m_cout));
            chk("m_zero",   32'(zero),   32'(m_zero));
        end
    end

    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic ci, input logic [W-1:0] er,
                          input logic ec, input logic ez);
        int  low;
        bit  seen;
        low  = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cin = ci;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk({nm, "_lat"},    32'(k),      32'd5);
                chk({nm, "_rdylow"}, 32'(low),    32'd5);
                chk({nm, "_result"}, 32'(result), 32'(er));
                chk({nm, "_cout"},   32'(cout),   32'(ec));
                chk({nm, "_zero"},   32'(zero),   32'(ez));
            end else if (!ready) begin
                low++;
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_done(input int cycles, output int n, output logic [W-1:0] last);
        n    = 0;
        last = '0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                n++;
                last = result;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [W-1:0] last;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(ready),  32'd1);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout",   32'(cout),   32'd0);
        chk("rst_zero",   32'(zero),   32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op("add_ff",   3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("add_cin",  3'b000, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0);
        run_op("and",      3'b001, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0);
        run_op("xor",      3'b101, 16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("nor",      3'b010, 16'h0F0F, 16'h00F0, 1'b0, 16'hF000, 1'b0, 1'b0);
        run_op("not",      3'b100, 16'h1234, 16'h0000, 1'b1, 16'hEDCB, 1'b0, 1'b0);
        run_op("or",       3'b011, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0);
        run_op("op111",    3'b111, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1);
        run_op("op110",    3'b110, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1);

        // starts while busy with different operands must be dropped
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 16'hFFFF; b = 16'h1234; cin = 1'b1;
        @(negedge clk);
        op = 3'b001; a = 16'h0F0F;
        @(negedge clk);
        op = 3'b000; a = 16'h8000; b = 16'h8000;
        count_done(14, n, last);
        chk("ign_done_cnt", 32'(n),    32'd1);
        chk("ign_result",   32'(last), 32'h0003);

        // reset during the second RUN cycle aborts the command
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",  32'(ready),  32'd1);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_result", 32'(result), 32'd0);
        count_done(10, n, last);
        chk("abort_no_done", 32'(n), 32'd0);
        run_op("add_after_rst", 3'b000, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 3'b000; a = 16'h0005; b = 16'h0005;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_ready", 32'(ready), 32'd1);
        chk("rst_start_busy",  32'(busy),  32'd0);
        count_done(8, n, last);
        chk("rst_start_no_done", 32'(n), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
